// File: rtl/oai32_sweep_pkg.sv
// Shared types and constants for the oai32 timing-arc sweep controller.
// The arc table covers every sensitizable arc of ZN = ~((A1|A2|A3) & (B1|B2)).
package oai32_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int NUM_ARCS = 23;
  localparam int ARC_W = 5;
  localparam logic [ARC_W-1:0] NO_FAIL_ARC = 5'h1F;
  localparam logic [ARC_W-1:0] LAST_ARC = 5'(NUM_ARCS - 1);
  localparam logic [1:0] NO_FAIL_STEP = 2'd3;

  // Target pin goes 0,1,0 across steps 0..2, so the ideal ZN is 1,0,1; bit 3 is unused.
  localparam logic [3:0] EXP_ZN = 4'b0101;

  function automatic logic exp_zn(input logic [1:0] step);
    return EXP_ZN[step];
  endfunction

endpackage

// File: rtl/oai32_arc_decode.sv
// Maps (arc, step) to the pin vector {A1,A2,A3,B1,B2} for the cell under test.
// Only the target pin depends on step; the sensitizing pins are fixed per arc.
module oai32_arc_decode
  import oai32_sweep_pkg::*;
(
  input  logic [ARC_W-1:0] arc_idx,
  input  logic [1:0]       step,
  output logic [4:0]       pins
);

  logic       tv;
  logic [2:0] a_sel;
  logic [1:0] b_sel;

  always_comb begin
    tv    = (step == 2'd1);
    a_sel = 3'b000;
    b_sel = 2'b00;
    pins  = 5'b00000;
    if (arc_idx < 5'd9) begin
      // A-pin arcs: one-hot A target, B side walks through 01, 10, 11
      if (arc_idx < 5'd3) begin
        a_sel = 3'b100;
        b_sel = arc_idx[1:0] + 2'd1;
      end else if (arc_idx < 5'd6) begin
        a_sel = 3'b010;
        b_sel = 2'(arc_idx - 5'd3) + 2'd1;
      end else begin
        a_sel = 3'b001;
        b_sel = 2'(arc_idx - 5'd6) + 2'd1;
      end
      pins = {(tv ? a_sel : 3'b000), b_sel};
    end else if (arc_idx < 5'd16) begin
      pins = {3'(arc_idx - 5'd8), tv, 1'b0};
    end else if (arc_idx <= LAST_ARC) begin
      pins = {3'(arc_idx - 5'd15), 1'b0, tv};
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai32_arc_sweep_ctrl.sv
// Sweeps all 23 conditional arcs of an oai32 cell, toggling each target 0->1->0
// and comparing the sampled ZN against the ideal function after a settle window.
//
// state  | meaning
// IDLE   | waiting for start; pins held at 0
// DRIVE  | register the vector for (arc_idx, step)
// SETTLE | wait SETTLE_CYC cycles for the cell output to settle
// CHECK  | compare zn_obs with the ideal value, count mismatches
// NEXT   | advance to the next arc or finish
// DONE   | one-cycle done pulse, pins back at 0
module gf180mcu_fd_sc_mcu7t5v0__oai32_arc_sweep_ctrl
  import oai32_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic             zn_obs,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B1,
  output logic             B2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ARC_W-1:0] first_fail_arc,
  output logic [1:0]       first_fail_step,
  output logic [ARC_W-1:0] arc_idx
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [1:0] step;
  logic [7:0] settle_cnt;
  logic [4:0] pins, vec;
  logic       mismatch;

  oai32_arc_decode u_decode (
    .arc_idx (arc_idx),
    .step    (step),
    .pins    (vec)
  );

  // X on zn_obs must count as a failure, hence the case inequality
  assign mismatch = (zn_obs !== exp_zn(step));

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state_nxt = ST_DRIVE;
        ST_DRIVE:  state_nxt = ST_SETTLE;
        ST_SETTLE: if (settle_cnt == 8'd0) state_nxt = ST_CHECK;
        ST_CHECK:  state_nxt = (step == 2'd2) ? ST_NEXT : ST_DRIVE;
        ST_NEXT:   state_nxt = (arc_idx == LAST_ARC) ? ST_DONE : ST_DRIVE;
        ST_DONE:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      pins            <= 5'b00000;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_fail_arc  <= NO_FAIL_ARC;
      first_fail_step <= NO_FAIL_STEP;
      arc_idx         <= '0;
      step            <= 2'd0;
      settle_cnt      <= 8'd0;
    end else if (abort) begin
      pins <= 5'b00000;
      pass <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_cnt         <= '0;
            first_fail_arc  <= NO_FAIL_ARC;
            first_fail_step <= NO_FAIL_STEP;
            pass            <= 1'b0;
            arc_idx         <= '0;
            step            <= 2'd0;
          end
        end
        ST_DRIVE: begin
          pins       <= vec;
          settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (!(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
            // err_cnt only grows within a sweep, so zero marks the first failure
            if (err_cnt == '0) begin
              first_fail_arc  <= arc_idx;
              first_fail_step <= step;
            end
          end
          if (step != 2'd2) step <= step + 2'd1;
        end
        ST_NEXT: begin
          if (arc_idx == LAST_ARC) begin
            pins <= 5'b00000;
            pass <= (err_cnt == '0);
          end else begin
            arc_idx <= arc_idx + 5'd1;
            step    <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign {A1, A2, A3, B1, B2} = pins;
  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai32_arc_sweep_ctrl.sv
// Bench for the oai32 arc sweep controller: table-driven full sweeps, randomized
// fault maps against a table-level reference model, and abort/reset sequences.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai32_arc_sweep_ctrl;

  logic       CLK, RN, start, abort, zn_obs;
  logic       A1, A2, A3, B1, B2, busy, done, pass;
  logic [7:0] err_cnt;
  logic [4:0] first_fail_arc, arc_idx;
  logic [1:0] first_fail_step;

  logic       zn_sat;
  logic       s_A1, s_A2, s_A3, s_B1, s_B2, s_busy, s_done, s_pass;
  logic [3:0] s_err;
  logic [4:0] s_ffa, s_arc;
  logic [1:0] s_ffs;

  int  mode;
  bit  flo [32];
  bit  fhi [32];
  int  checks = 0;
  int  errors = 0;

  logic [4:0] pin_q[$];
  logic [4:0] last_pins;

  gf180mcu_fd_sc_mcu7t5v0__oai32_arc_sweep_ctrl #(.SETTLE_CYC(4), .CNT_W(8)) dut (
    .CLK(CLK), .RN(RN), .start(start), .abort(abort), .zn_obs(zn_obs),
    .A1(A1), .A2(A2), .A3(A3), .B1(B1), .B2(B2),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_arc(first_fail_arc), .first_fail_step(first_fail_step), .arc_idx(arc_idx)
  );

  // Narrow counter fed a stuck-at-0 ZN: always saturates
  gf180mcu_fd_sc_mcu7t5v0__oai32_arc_sweep_ctrl #(.SETTLE_CYC(4), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RN(RN), .start(start), .abort(abort), .zn_obs(zn_sat),
    .A1(s_A1), .A2(s_A2), .A3(s_A3), .B1(s_B1), .B2(s_B2),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
    .first_fail_arc(s_ffa), .first_fail_step(s_ffs), .arc_idx(s_arc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Pin vector for an arc/step, straight from the arc table rules
  function automatic logic [4:0] arc_vec(int arc, int step);
    logic       tv;
    logic [2:0] a;
    logic [1:0] b;
    tv = (step == 1);
    if (arc < 9) begin
      a = tv ? 3'(4 >> (arc / 3)) : 3'd0;
      b = 2'(arc % 3 + 1);
    end else if (arc < 16) begin
      a = 3'(arc - 8);
      b = {tv, 1'b0};
    end else begin
      a = 3'(arc - 15);
      b = {1'b0, tv};
    end
    return {a, b};
  endfunction

  // Behaviour of the cell under test: 0 ideal, 1 stuck-1, 2 stuck-0, 3 B2 tied low, 4 fault map
  function automatic logic cell_zn(int m, logic [4:0] p, int arc);
    logic ideal;
    ideal = ~((p[4] | p[3] | p[2]) & (p[1] | p[0]));
    case (m)
      1: return 1'b1;
      2: return 1'b0;
      3: return ~((p[4] | p[3] | p[2]) & p[1]);
      4: return ideal ^ (ideal ? flo[arc] : fhi[arc]);
      default: return ideal;
    endcase
  endfunction

  assign zn_obs = cell_zn(mode, {A1, A2, A3, B1, B2}, int'(arc_idx));
  assign zn_sat = 1'b0;

  always @(negedge CLK) begin
    if ({A1, A2, A3, B1, B2} != last_pins) begin
      pin_q.push_back({A1, A2, A3, B1, B2});
      last_pins = {A1, A2, A3, B1, B2};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic ref_sweep(input int m, output int e, output int fa, output int fs);
    logic z;
    e = 0; fa = 31; fs = 3;
    for (int arc = 0; arc < 23; arc++) begin
      for (int st = 0; st < 3; st++) begin
        z = cell_zn(m, arc_vec(arc, st), arc);
        if (z !== ((st == 1) ? 1'b0 : 1'b1)) begin
          if (e == 0) begin fa = arc; fs = st; end
          if (e < 255) e++;
        end
      end
    end
  endtask

  task automatic run_sweep(output int lat);
    pin_q.delete();
    last_pins = 5'b00000;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic check_pins();
    int bad;
    logic [4:0] exp_v;
    bad = -1;
    for (int i = 0; i < 70 && i < pin_q.size(); i++) begin
      exp_v = (i == 69) ? 5'b00000 : arc_vec(i / 3, i % 3);
      if (bad < 0 && pin_q[i] !== exp_v) bad = i;
    end
    check("pin_seq_len", pin_q.size(), 70);
    check("pin_seq_first_bad", bad, -1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_ffa"}, first_fail_arc, 31);
    check({tag, "_ffs"}, first_fail_step, 3);
    check({tag, "_arc"}, arc_idx, 0);
    check({tag, "_pins"}, {A1, A2, A3, B1, B2}, 0);
    check({tag, "_sat_err"}, s_err, 0);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    err;
    int    ffa;
    int    ffs;
    int    pass;
  } row_t;

  row_t rows[4];

  initial begin
    int lat, e, fa, fs, cnt_done;

    // B2 tied low also breaks arcs 0,3,6, whose only active B pin is B2
    rows[0] = '{"ideal",    0, 0,  31, 3, 1};
    rows[1] = '{"stuck1",   1, 23, 0,  1, 0};
    rows[2] = '{"stuck0",   2, 46, 0,  0, 0};
    rows[3] = '{"b2_low",   3, 10, 0,  1, 0};

    mode = 0; RN = 1'b0; start = 1'b0; abort = 1'b0; last_pins = 5'b00000;
    for (int i = 0; i < 32; i++) begin flo[i] = 1'b0; fhi[i] = 1'b0; end
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    RN = 1'b1;
    @(negedge CLK);

    for (int r = 0; r < 4; r++) begin
      mode = rows[r].mode;
      run_sweep(lat);
      check({rows[r].name, "_latency"}, lat, 438);
      check({rows[r].name, "_err"}, err_cnt, rows[r].err);
      check({rows[r].name, "_ffa"}, first_fail_arc, rows[r].ffa);
      check({rows[r].name, "_ffs"}, first_fail_step, rows[r].ffs);
      check({rows[r].name, "_pass"}, pass, rows[r].pass);
      check({rows[r].name, "_busy_at_done"}, busy, 0);
      check({rows[r].name, "_sat_err"}, s_err, 15);
      check({rows[r].name, "_sat_ffa"}, s_ffa, 0);
      check({rows[r].name, "_sat_ffs"}, s_ffs, 0);
      check({rows[r].name, "_sat_pass"}, s_pass, 0);
      @(negedge CLK);
      check({rows[r].name, "_done_pulse"}, done, 0);
      check_pins();
    end

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 23; i++) begin
        flo[i] = ($urandom_range(0, 7) == 0);
        fhi[i] = ($urandom_range(0, 7) == 0);
      end
      if (k == 0) fhi[22] = 1'b1;
      mode = 4;
      ref_sweep(4, e, fa, fs);
      run_sweep(lat);
      check("rand_latency", lat, 438);
      check("rand_err", err_cnt, e);
      check("rand_ffa", first_fail_arc, fa);
      check("rand_ffs", first_fail_step, fs);
      check("rand_pass", pass, (e == 0) ? 1 : 0);
      @(negedge CLK);
    end

    // Abort at cycle 100 of a stuck-1 sweep
    mode = 1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (99) @(negedge CLK);
    check("abort_pre_arc", arc_idx, 5);
    check("abort_pre_err", err_cnt, 5);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_pins", {A1, A2, A3, B1, B2}, 0);
    check("abort_pass", pass, 0);
    check("abort_err_kept", err_cnt, 5);
    check("abort_ffa_kept", first_fail_arc, 0);
    check("abort_ffs_kept", first_fail_step, 1);
    cnt_done = 0;
    repeat (500) begin
      @(negedge CLK);
      if (done || busy) cnt_done++;
    end
    check("abort_no_done", cnt_done, 0);
    mode = 0;
    run_sweep(lat);
    check("post_abort_latency", lat, 438);
    check("post_abort_pass", pass, 1);
    check("post_abort_err", err_cnt, 0);
    @(negedge CLK);

    // Reset during arc 12 with start held high, abort also asserted
    mode = 1;
    start = 1'b1;
    repeat (235) @(negedge CLK);
    check("rn_pre_arc", arc_idx, 12);
    check("rn_pre_err", err_cnt, 12);
    RN = 1'b0;
    abort = 1'b1;
    @(negedge CLK);
    check_reset_vals("midreset");
    RN = 1'b1;
    abort = 1'b0;
    mode = 0;
    @(negedge CLK);
    check("relaunch_busy", busy, 1);
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge CLK);
      lat++;
      if (lat == 50) check("held_start_arc", arc_idx, 2);
    end
    check("held_latency", lat, 438);
    check("held_pass", pass, 1);
    @(negedge CLK);
    check("held_idle_gap", busy, 0);
    @(negedge CLK);
    check("held_relaunch", busy, 1);
    start = 1'b0;
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("final_abort_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
